// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: timer-driven round-robin A2D sampling with on-demand host reads over a shared SPI master
module a2d_conv_sched #(
  parameter int PERIOD_W = 14,
  parameter logic [2:0] BATT_CH = 3'd0,
  parameter logic [2:0] CURR_CH = 3'd1,
  parameter logic [2:0] BRAKE_CH = 3'd3,
  parameter logic [2:0] TORQUE_CH = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        rnd_cmplt,
  input  logic        req,
  input  logic [2:0]  req_ch,
  output logic        req_ack,
  output logic [11:0] req_data
);
  typedef enum logic [2:0] {IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2} state_t;
  state_t state, nxt;
  logic [PERIOD_W-1:0] timer;
  logic tick, pend, rnd_act, host, cap, unused_resp;
  logic [1:0] slot;
  logic [2:0] hch, ch, slot_ch;
  logic [3:0] wr;
  assign tick = &timer;
  assign slot_ch = slot == 2'd0 ? BATT_CH : slot == 2'd1 ? CURR_CH : slot == 2'd2 ? BRAKE_CH : TORQUE_CH;
  assign cmd = {2'b00, ch, 11'h000};
  assign snd = state == SEND1 || state == SEND2;
  assign cap = state == WAIT2 && done;
  assign wr = host ? {ch == TORQUE_CH, ch == BRAKE_CH, ch == CURR_CH, ch == BATT_CH} : 4'b0001 << slot;
  assign unused_resp = ^resp[15:12];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = (pend || rnd_act || tick) ? SEND1 : IDLE;
      SEND1: nxt = WAIT1;
      WAIT1: nxt = done ? GAP : WAIT1;
      GAP:   nxt = SEND2;
      SEND2: nxt = WAIT2;
      WAIT2: nxt = done ? IDLE : WAIT2;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      pend <= 1'b0;
      hch <= 3'd0;
      rnd_act <= 1'b0;
      slot <= 2'd0;
      host <= 1'b0;
      ch <= 3'd0;
      batt <= 12'h000;
      curr <= 12'h000;
      brake <= 12'h000;
      torque <= 12'h000;
      req_data <= 12'h000;
      rnd_cmplt <= 1'b0;
      req_ack <= 1'b0;
    end else begin
      timer <= timer + 1'b1;
      rnd_cmplt <= 1'b0;
      req_ack <= 1'b0;
      if (req && !pend) begin
        pend <= 1'b1;
        hch <= req_ch;
      end
      if (state == IDLE) begin
        if (pend) begin
          host <= 1'b1;
          ch <= hch;
        end else if (rnd_act) begin
          host <= 1'b0;
          ch <= slot_ch;
        end else if (tick) begin
          host <= 1'b0;
          ch <= BATT_CH;
          rnd_act <= 1'b1;
          slot <= 2'd0;
        end
      end
      if (cap) begin
        if (wr[0]) batt <= resp[11:0];
        if (wr[1]) curr <= resp[11:0];
        if (wr[2]) brake <= resp[11:0];
        if (wr[3]) torque <= resp[11:0];
        if (host) begin
          req_data <= resp[11:0];
          req_ack <= 1'b1;
          pend <= 1'b0;
        end else begin
          slot <= slot + 1'b1;
          if (slot == 2'd3) begin
            rnd_act <= 1'b0;
            rnd_cmplt <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_a2d_conv_sched.sv
// tb_a2d_conv_sched: scoreboard bench with an SPI responder and a conversion-level reference model
module tb_a2d_conv_sched;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0, req = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic [2:0] req_ch = 3'd0;
  logic snd, rnd_cmplt, req_ack;
  logic [15:0] cmd;
  logic [11:0] batt, curr, brake, torque, req_data;
  always #5 clk = ~clk;
  a2d_conv_sched #(.PERIOD_W(8)) dut (
    .clk(clk), .rst(rst), .snd(snd), .cmd(cmd), .done(done), .resp(resp),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque), .rnd_cmplt(rnd_cmplt),
    .req(req), .req_ch(req_ch), .req_ack(req_ack), .req_data(req_data)
  );
  typedef struct {int cyc; logic [11:0] d; logic [47:0] regs;} ev_t;
  ev_t ack_q[$], rnd_q[$];
  int n_vec = 0, n_fail = 0, cyc = 0, T = 32, phase = 0, done_at = -1, exp_snd = 0;
  int idle_from = 0, acc_cyc = 0, m_slot = 0, ack_cnt = 0, rnd_cnt = 0;
  bit m_round = 0, m_pend = 0, cur_host = 0, fixed_resp = 1, inject = 0;
  logic [2:0] m_hch = 3'd0, cur_ch = 3'd0;
  logic [11:0] m_reg [4];
  logic [15:0] cur_resp = 16'h0000;

  function automatic logic [2:0] slot_ch(input int s);
    return s == 0 ? 3'd0 : s == 1 ? 3'd1 : s == 2 ? 3'd3 : 3'd4;
  endfunction
  function automatic logic [47:0] regs_now();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction
  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI responder plus reference model of which conversion must run and when
  initial begin : model
    logic r;
    int e;
    logic [11:0] v;
    foreach (m_reg[i]) m_reg[i] = 12'h000;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        cyc = 0; phase = 0; done_at = -1; idle_from = 0;
        m_round = 0; m_slot = 0; m_pend = 0;
        foreach (m_reg[i]) m_reg[i] = 12'h000;
        ack_q.delete(); rnd_q.delete();
      end else cyc++;
      done = 1'b0;
      if (!r && cyc == done_at) begin
        cur_resp = (phase == 3 && fixed_resp) ? {4'hF, cur_ch, 9'h0AB} : 16'($urandom);
        done = 1'b1;
        resp = cur_resp;
      end else if (inject) begin
        done = 1'b1;
        resp = 16'($urandom);
        inject = 0;
      end
      @(negedge clk);
      if (req && !m_pend) begin
        m_pend = 1; m_hch = req_ch; acc_cyc = cyc;
      end
      if (snd) begin
        if (phase == 0) begin
          if (m_pend && acc_cyc <= cyc - 2) begin
            cur_host = 1; cur_ch = m_hch;
            e = (idle_from > acc_cyc + 1 ? idle_from : acc_cyc + 1) + 1;
          end else if (m_round) begin
            cur_host = 0; cur_ch = slot_ch(m_slot); e = idle_from + 1;
          end else begin
            cur_host = 0; m_round = 1; m_slot = 0; cur_ch = slot_ch(0);
            e = ((idle_from + 256) / 256) * 256;
          end
          chk("snd1_cycle", cyc, e);
          phase = 1;
        end else if (phase == 2) begin
          chk("snd2_cycle", cyc, exp_snd);
          phase = 3;
        end else begin
          n_vec++; n_fail++;
          $display("FAIL snd_outstanding: snd at cycle %0d while phase %0d", cyc, phase);
        end
        chk("cmd", cmd, {2'b00, cur_ch, 11'h000});
        done_at = cyc + T;
      end else if (phase == 2 && cyc > exp_snd) begin
        n_vec++; n_fail++;
        $display("FAIL snd2_missing: none by cycle %0d, required at %0d", cyc, exp_snd);
        phase = 0;
      end
      if (done && cyc == done_at) begin
        if (phase == 1) begin
          phase = 2; exp_snd = cyc + 2;
        end else if (phase == 3) begin
          v = cur_resp[11:0];
          if (cur_host) begin
            m_pend = 0;
            if (cur_ch == 3'd0) m_reg[0] = v;
            if (cur_ch == 3'd1) m_reg[1] = v;
            if (cur_ch == 3'd3) m_reg[2] = v;
            if (cur_ch == 3'd4) m_reg[3] = v;
            ack_q.push_back('{cyc + 1, v, regs_now()});
          end else begin
            m_reg[m_slot] = v;
            if (m_slot == 3) begin
              m_round = 0; m_slot = 0;
              rnd_q.push_back('{cyc + 1, 12'h000, regs_now()});
            end else m_slot++;
          end
          idle_from = cyc + 1;
          phase = 0;
        end
      end
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (req_ack) begin
        if (ack_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL req_ack_spurious: pulse at cycle %0d, none owed", cyc);
        end else begin
          e = ack_q.pop_front();
          chk("req_ack_cycle", cyc, e.cyc);
          chk("req_data", req_data, e.d);
          chk("regs_at_ack", {torque, brake, curr, batt}, e.regs);
          ack_cnt++;
        end
      end else if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
        n_vec++; n_fail++;
        $display("FAIL req_ack_missing: none at cycle %0d", ack_q[0].cyc);
        void'(ack_q.pop_front());
      end
      if (rnd_cmplt) begin
        if (rnd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rnd_cmplt_spurious: pulse at cycle %0d", cyc);
        end else begin
          e = rnd_q.pop_front();
          chk("rnd_cmplt_cycle", cyc, e.cyc);
          chk("regs_at_rnd", {torque, brake, curr, batt}, e.regs);
          rnd_cnt++;
        end
      end else if (rnd_q.size() > 0 && rnd_q[0].cyc < cyc) begin
        n_vec++; n_fail++;
        $display("FAIL rnd_cmplt_missing: none at cycle %0d", rnd_q[0].cyc);
        void'(rnd_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_model(input bit rnd, input int slot, input int ph, input string what);
    int k = 0;
    while (!(m_round == rnd && (slot < 0 || m_slot == slot) && phase == ph)) begin
      step(1);
      if (++k > 6000) begin
        n_vec++; n_fail++;
        $display("FAIL timeout_%s: condition not reached in 6000 cycles", what);
        return;
      end
    end
  endtask
  task automatic wait_cnt(input bit is_ack, input int target, input string what);
    int k = 0;
    while ((is_ack ? ack_cnt : rnd_cnt) < target) begin
      step(1);
      if (++k > 12000) begin
        n_vec++; n_fail++;
        $display("FAIL timeout_%s: count %0d, required %0d", what, is_ack ? ack_cnt : rnd_cnt, target);
        return;
      end
    end
  endtask
  task automatic host_req(input logic [2:0] ch, input int n);
    req = 1'b1; req_ch = ch;
    step(n);
    req = 1'b0;
  endtask
  task automatic chk_zero(input string what);
    chk({what, "_batt"}, batt, 0);
    chk({what, "_curr"}, curr, 0);
    chk({what, "_brake"}, brake, 0);
    chk({what, "_torque"}, torque, 0);
    chk({what, "_req_data"}, req_data, 0);
    chk({what, "_snd"}, snd, 0);
    chk({what, "_cmd"}, cmd, 0);
  endtask

  initial begin : stim
    logic [47:0] snap;
    int s, p;
    step(3);
    rst = 1'b0;
    chk_zero("reset");
    chk("reset_rnd_cmplt", rnd_cmplt, 0);
    chk("reset_req_ack", req_ack, 0);
    wait_cnt(0, 1, "round1");
    chk("round1_batt", batt, 12'h0AB);
    chk("round1_curr", curr, 12'h2AB);
    chk("round1_brake", brake, 12'h6AB);
    chk("round1_torque", torque, 12'h8AB);
    wait_model(1, 1, 1, "slot1_wait1");
    host_req(3'd3, 1);
    wait_cnt(1, 1, "ack_ch3");
    chk("host3_req_data", req_data, 12'h6AB);
    chk("host3_brake", brake, 12'h6AB);
    wait_cnt(0, 2, "round2");
    chk("host3_ack_count", ack_cnt, 1);
    fixed_resp = 0;
    wait_model(0, -1, 0, "idle_ch7");
    snap = regs_now();
    host_req(3'd7, 5);
    wait_cnt(1, 2, "ack_ch7");
    step(80);
    chk("ch7_ack_count", ack_cnt, 2);
    chk("ch7_regs_unchanged", {torque, brake, curr, batt}, snap);
    for (int i = 0; i < 4; i++) begin
      T = $urandom_range(2, 40);
      s = $urandom_range(0, 3);
      p = $urandom_range(0, 1) ? 1 : 3;
      wait_model(1, s, p, "rand_slot");
      host_req(3'($urandom_range(0, 7)), 1);
      wait_cnt(1, ack_cnt + 1, "rand_ack");
    end
    wait_model(0, -1, 0, "idle_t1");
    T = 1;
    wait_cnt(0, rnd_cnt + 1, "round_t1");
    wait_model(0, -1, 0, "idle_t300");
    T = 300;
    wait_cnt(0, rnd_cnt + 2, "round_t300");
    T = 32;
    wait_model(1, 2, 3, "slot2_wait2");
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_zero("midrst");
    step(100);
    inject = 1;
    step(5);
    chk("inject_regs", {torque, brake, curr, batt}, 48'h0);
    chk("inject_req_ack_count", ack_cnt, 6);
    wait_cnt(0, rnd_cnt + 1, "round_after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/a2d_conv_sched.md
Name: a2d_conv_sched

Overview:
- Schedules conversions on the eBike's shared SPI A2D channel. It drives the SPI master handshake (snd/cmd/done/resp).
- A free-running timer starts a periodic round-robin round over four sensor channels: battery, motor current, brake, torque.
- A single host port can insert an on-demand read of any channel between round slots.
- Holds the latest 12-bit result for each channel for sensor conditioning and the PID path.

Parameters:
- PERIOD_W, 14: width of the round timer. A round starts every 2^PERIOD_W clocks.
- BATT_CH, 3'd0: A2D channel address for battery.
- CURR_CH, 3'd1: A2D channel address for motor current.
- BRAKE_CH, 3'd3: A2D channel address for brake.
- TORQUE_CH, 3'd4: A2D channel address for torque.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- snd  out  1  one-cycle pulse that starts an SPI transaction.
- cmd  out  16  SPI command word, {2'b00, ch[2:0], 11'h000}.
- done  in  1  one-cycle pulse from the SPI master when a transaction completes.
- resp  in  16  SPI response word; valid when done=1.
- batt  out  12  latest battery result.
- curr  out  12  latest current result.
- brake  out  12  latest brake result.
- torque  out  12  latest torque result.
- rnd_cmplt  out  1  one-cycle pulse when all four round slots are done.
- req  in  1  host on-demand read request.
- req_ch  in  3  channel for the host request; sampled together with req.
- req_ack  out  1  one-cycle pulse; req_data is valid on this cycle.
- req_data  out  12  result of the host read; held until the next req_ack.

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE; timer, slot index and pending flag clear.
  - All outputs go to 0; cmd=16'h0000.
  - A transaction in progress is abandoned. The SPI master shares rst, so no stale done is expected; any done seen outside WAIT1/WAIT2 is ignored.
- Timer:
  - PERIOD_W-bit counter, increments every clock and wraps.
  - tick = timer all-ones. The first tick comes at cycle 2^PERIOD_W-1 after reset release.
  - A tick that arrives while a round is active is dropped, not queued.
- Host port:
  - If req=1 and pend=0, set pend and latch req_ch.
  - If req=1 while pend=1, the request is ignored. No ack is owed for it.
- One conversion = two SPI transactions with the same cmd. The first sets the channel address; the second returns data.
- States:
  - IDLE (arbitration):
    - If pend: serve the host channel → SEND1.
    - Else if a round is active: serve the channel for slot → SEND1.
    - Else if tick: set round active, slot=0 → SEND1.
    - Host beats round: when a slot finishes and pend=1, the host read runs before the next slot.
  - SEND1: snd=1 for one cycle; cmd holds the selected channel from this cycle until the conversion ends → WAIT1.
  - WAIT1: on done → GAP.
  - GAP: one idle cycle, so snd is never asserted in the same cycle done is sampled → SEND2.
  - SEND2: snd=1 for one cycle → WAIT2.
  - WAIT2: on done, at that posedge:
    - Capture resp[11:0] into the destination register, visible the next cycle. Upper resp bits are discarded.
    - Round conversion: write the slot's output register. Slot order is 0 batt, 1 curr, 2 brake, 3 torque. Increment slot. After slot 3, clear round active and pulse rnd_cmplt the next cycle.
    - Host conversion: write req_data, pulse req_ack the next cycle, clear pend. If req_ch matches a mapped channel address, also update that output register. Slot is unchanged.
    - → IDLE.
- Latency:
  - With no contention and the SPI taking T clocks from snd to done, result-visible = tick/accept + 2T + 4 clocks.
  - IDLE returns to SEND1 with no extra cycle: IDLE decides and SEND1 follows at the next edge.
- snd never stays high for two consecutive cycles. Only one SPI transaction is ever outstanding.

Test Plan:
- Run with PERIOD_W=8 and an SPI model that has T=32 and resp={4'hF, ch, 9'h0AB}. After release, check:
  - first snd at cycle 256;
  - channel sequence 0,0,1,1,3,3,4,4;
  - each output equals its low 12 bits, e.g. batt=12'h0AB, torque=12'h8AB;
  - one rnd_cmplt pulse.
- Assert req with req_ch=3'd3 mid-slot-1 of a round → curr finishes, then the ch3 pair runs; req_ack pulses once; req_data=brake=12'h6AB; then slot 2 (brake) runs normally.
- Hold req high for 5 cycles with req_ch=3'd7 while IDLE → exactly one conversion on ch7; one req_ack; no output register changes.
- Set T=300 with PERIOD_W=8 → a round spans the next tick; that tick is dropped; the next round starts at the following tick only after rnd_cmplt.
- Pulse rst during WAIT2 of slot 2 → all outputs are 0 the next cycle; snd stays low until the tick at 255 clocks after release; a done injected in IDLE changes nothing.
- Inject done one cycle after SEND1 (T=1) → GAP is still honoured; snd pulses are separated by at least 2 cycles; the result is correct.
